// File: rtl/u_game_judge_combo_seg_if.sv
// Judge-in / 7-segment-out bundle for u_game_judge_combo_seg.
// master drives i_judge_vld, i_judge, i_clear; slave drives o_seg, o_com, o_combo, o_bcd_busy.
`timescale 1ns/1ps
interface u_game_judge_combo_seg_if #(
    parameter int N_DIGITS = 8,
    parameter int COMBO_W  = 10
);
    logic                i_judge_vld;
    logic [1:0]          i_judge;
    logic                i_clear;
    logic [7:0]          o_seg;
    logic [N_DIGITS-1:0] o_com;
    logic [COMBO_W-1:0]  o_combo;
    logic                o_bcd_busy;

    modport master (
        output i_judge_vld, i_judge, i_clear,
        input  o_seg, o_com, o_combo, o_bcd_busy
    );

    modport slave (
        input  i_judge_vld, i_judge, i_clear,
        output o_seg, o_com, o_combo, o_bcd_busy
    );
endinterface

// File: rtl/u_game_judge_combo_seg.sv
// Rhythm-game judgement word / combo count on a multiplexed N-digit 7-seg bank.
// Ports: clk, rst (async high); bus.slave: judge strobe/code, clear in; seg, com, combo, bcd busy out.
`timescale 1ns/1ps
module u_game_judge_combo_seg #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 16384,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int COMBO_DIGITS = 3,
    parameter int COMBO_W      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    u_game_judge_combo_seg_if.slave  bus
);
    localparam int IW = $clog2(N_DIGITS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int CW = $clog2(COMBO_W);
    localparam int BW = 4 * COMBO_DIGITS;
    localparam int COMBO_MAX = 10 ** COMBO_DIGITS - 1;

    typedef enum logic [1:0] {ST_IDLE, ST_JUDGE, ST_COMBO} state_t;

    state_t             r_state, w_state_nxt;
    logic [DW-1:0]      r_div;
    logic [IW-1:0]      r_idx;
    logic [HW-1:0]      r_hold;
    logic [1:0]         r_judge;
    logic [COMBO_W-1:0] r_combo, w_combo_nxt;
    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [COMBO_W-1:0] r_sh_bin;
    logic [BW-1:0]      r_sh_bcd, r_bcd;
    logic [BW-1:0]      w_bcd_adj, w_bcd_shift, w_hi;
    logic [7:0]         r_seg, w_glyph;
    logic [N_DIGITS-1:0] r_com;
    logic               w_evt, w_chg;
    int                 w_k;

    function automatic logic [7:0] f_dec(input logic [3:0] v);
        case (v)
            4'd0: f_dec = 8'hC0;
            4'd1: f_dec = 8'hF9;
            4'd2: f_dec = 8'hA4;
            4'd3: f_dec = 8'hB0;
            4'd4: f_dec = 8'h99;
            4'd5: f_dec = 8'h92;
            4'd6: f_dec = 8'h82;
            4'd7: f_dec = 8'hF8;
            4'd8: f_dec = 8'h80;
            4'd9: f_dec = 8'h90;
            default: f_dec = 8'hFF;
        endcase
    endfunction

    // k counts digits from the left edge of the bank
    function automatic logic [7:0] f_word(input logic [1:0] j, input int k);
        f_word = 8'hFF;
        case (j)
            2'b11: case (k)
                0: f_word = 8'h0C;
                1: f_word = 8'h06;
                2: f_word = 8'hAF;
                3: f_word = 8'h0E;
                4: f_word = 8'h06;
                5: f_word = 8'h46;
                6: f_word = 8'h07;
                default: f_word = 8'hFF;
            endcase
            2'b10: case (k)
                0: f_word = 8'hAB;
                1: f_word = 8'hA3;
                2: f_word = 8'hAF;
                3: f_word = 8'hAB;
                4: f_word = 8'h08;
                5: f_word = 8'h87;
                default: f_word = 8'hFF;
            endcase
            2'b01: case (k)
                2: f_word = 8'hAB;
                3: f_word = 8'hF9;
                4: f_word = 8'h12;
                5: f_word = 8'h12;
                default: f_word = 8'hFF;
            endcase
            default: f_word = 8'hFF;
        endcase
    endfunction

    assign w_evt = bus.i_judge_vld && (bus.i_judge != 2'b00);

    always_comb begin
        w_combo_nxt = r_combo;
        if (w_evt) begin
            if (bus.i_judge == 2'b01)
                w_combo_nxt = '0;
            else if (r_combo != COMBO_W'(COMBO_MAX))
                w_combo_nxt = r_combo + 1'b1;
        end
    end

    assign w_chg = (w_combo_nxt != r_combo);

    // digit index walks left-to-right, wrapping without a power-of-2 mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DW'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == '0) ? IW'(N_DIGITS - 1) : r_idx - 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_evt) w_state_nxt = ST_JUDGE;
            ST_JUDGE: if (!w_evt && r_hold == HW'(HOLD_CYC - 1))
                          w_state_nxt = ST_COMBO;
            ST_COMBO: if (w_evt) w_state_nxt = ST_JUDGE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (bus.i_clear) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold  <= '0;
            r_judge <= 2'b00;
        end else if (w_evt && !bus.i_clear) begin
            r_hold  <= '0;
            r_judge <= bus.i_judge;
        end else if (r_state == ST_JUDGE && r_hold != HW'(HOLD_CYC - 1)) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    // double-dabble: add 3 to nibbles >= 5, then shift one binary bit in
    always_comb begin
        w_bcd_adj = r_sh_bcd;
        for (int i = 0; i < COMBO_DIGITS; i++)
            if (r_sh_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_sh_bcd[4*i +: 4] + 4'd3;
        w_bcd_shift = BW'({w_bcd_adj, r_sh_bin[COMBO_W-1]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_combo  <= '0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_sh_bin <= '0;
            r_sh_bcd <= '0;
            r_bcd    <= '0;
        end else if (bus.i_clear) begin
            r_combo <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else begin
            r_combo <= w_combo_nxt;
            if (w_chg) begin
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_sh_bin <= w_combo_nxt;
                r_sh_bcd <= '0;
            end else if (r_busy) begin
                r_sh_bin <= r_sh_bin << 1;
                r_sh_bcd <= w_bcd_shift;
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == CW'(COMBO_W - 1)) begin
                    r_busy <= 1'b0;
                    r_bcd  <= w_bcd_shift;
                end
            end
        end
    end

    // w_hi holds this digit and everything above it, for leading-zero blanking
    always_comb begin
        w_glyph = 8'hFF;
        w_k     = N_DIGITS - 1 - int'(r_idx);
        w_hi    = r_bcd >> {r_idx, 2'b00};
        unique case (r_state)
            ST_JUDGE: w_glyph = f_word(r_judge, w_k);
            ST_COMBO: if (int'(r_idx) < COMBO_DIGITS &&
                          (r_idx == '0 || w_hi != '0))
                          w_glyph = f_dec(w_hi[3:0]);
            default:  w_glyph = 8'hFF;
        endcase
    end

    // seg and com share one register stage so they always track the same digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= 8'hFF;
            r_com <= '1;
        end else begin
            r_seg <= w_glyph;
            r_com <= ~(N_DIGITS'(1) << r_idx);
        end
    end

    assign bus.o_seg      = r_seg;
    assign bus.o_com      = r_com;
    assign bus.o_combo    = r_combo;
    assign bus.o_bcd_busy = r_busy;
endmodule

// File: doc/u_game_judge_combo_seg.md
Name: u_game_judge_combo_seg

Overview:
Parametrised successor to the 8-digit judgement display for the rhythm game. It latches each judgement event and shows the judgement word on a multiplexed N-digit 7-segment bank for a fixed hold time. It then switches to a right-justified decimal combo count, which it maintains internally. It sits between the judge logic and the board 7-segment pins.

Parameters:
N_DIGITS, 8, number of multiplexed digits; legal 8..16.
SCAN_DIV, 16384, clk cycles each digit stays selected; legal ≥2.
HOLD_CYC, 25_000_000, clk cycles a judgement word stays shown; legal ≥1.
COMBO_DIGITS, 3, decimal digits of combo shown; legal 1..N_DIGITS.
COMBO_W, 10, combo counter width; must satisfy 2^COMBO_W > 10^COMBO_DIGITS-1.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
i_judge_vld  in  1  one-cycle strobe; i_judge is valid this cycle
i_judge  in  2  00 IDLE, 01 MISS, 10 NORMAL, 11 PERFECT
i_clear  in  1  synchronous clear: combo=0, state=IDLE
o_seg  out  8  segment pattern, active-low, bit0=a..bit6=g, bit7=dp
o_com  out  N_DIGITS  digit select, active-low one-hot; bit N_DIGITS-1 is the leftmost digit
o_combo  out  COMBO_W  current binary combo count
o_bcd_busy  out  1  high while the binary-to-BCD conversion runs

Behaviour:
- Reset state: o_seg=8'hFF, o_com=all ones, o_combo=0, o_bcd_busy=0, FSM=IDLE, BCD register=0, scan index=0, dwell counter=0.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances N_DIGITS-1 → N_DIGITS-2 … → 0 → N_DIGITS-1 (wraps; no power-of-2 assumption).
  - o_com and o_seg are registered. They reflect the current index 1 cycle later and are never both driven from different indices.
- Event accept: i_judge_vld=1 with i_judge≠00 is an event. A strobe with 00 is ignored.
- Combo on event:
  - NORMAL or PERFECT: combo+1, saturating at COMBO_MAX=10^COMBO_DIGITS-1.
  - MISS: combo=0.
  - o_combo updates the cycle after the strobe.
- i_clear has priority over a same-cycle event. It sets combo=0, FSM=IDLE, aborts any conversion, loads BCD=0 and drops o_bcd_busy.
- FSM states:
  - IDLE: all digits blank. Event → SHOW_JUDGE.
  - SHOW_JUDGE: shows the latched judgement word; hold counter runs. When the hold counter reaches HOLD_CYC-1 → SHOW_COMBO.
  - SHOW_COMBO: shows the combo. Event → SHOW_JUDGE.
  - An event in SHOW_JUDGE relatches the judgement and restarts the hold counter from 0.
- Word layout (digit index d, leftmost T=N_DIGITS-1; unlisted digits blank 8'hFF):
  - PERFECT: T..T-6 = P 0C, E 06, r AF, F 0E, E 06, C 46, t 07.
  - NORMAL: T..T-5 = n AB, o A3, r AF, n AB, A 08, L 87.
  - MISS: T-2..T-5 = n AB, I F9, S 12, S 12.
- Combo layout:
  - Digits COMBO_DIGITS-1..0 show BCD digits, units at d=0.
  - Leading zeros are blanked; value 0 shows a single "0" (8'hC0) at d=0.
  - Digits above COMBO_DIGITS-1 are blank.
  - Decimal glyphs 0..9: C0 F9 A4 B0 99 92 82 F8 80 90.
- BCD conversion:
  - Sequential double-dabble, one shift per cycle, COMBO_W cycles total.
  - Starts the cycle after any combo change. o_bcd_busy is high for exactly COMBO_W cycles.
  - A combo change while busy restarts the conversion from the new value.
  - The BCD display register updates only on completion, so the display never shows a partial value.
- Saturation: at COMBO_MAX, further hits leave combo unchanged and start no conversion.
- Reset mid-operation returns to the reset state immediately (async); scanning restarts at index 0.

Test Plan:
Use SCAN_DIV=4, HOLD_CYC=20, N_DIGITS=8, COMBO_DIGITS=3, COMBO_W=10.
1. Reset, no events → o_com cycles FE,7F,BF,…,FD every 4 cycles after index 0; o_seg=FF throughout.
2. PERFECT strobe → o_combo=1; o_bcd_busy high exactly 10 cycles. Over one scan, digit7..1 = 0C,06,AF,0E,06,46,07 and digit0=FF. After 20 cycles, digit0=F9 and all others FF.
3. 12 NORMAL strobes 30 cycles apart, then MISS → combo shows "12" (d1=F9, d0=A4) after the 12th. MISS word appears on d5..d2 = AB,F9,12,12; after hold, d0=C0 and o_combo=0.
4. Two PERFECT strobes 3 cycles apart → conversion restarts, single final BCD=2. Hold expires 20 cycles after the second strobe.
5. Preload 998 hits, then 3 more → o_combo saturates at 999; display shows 90,90,90 on d2..d0.
6. i_clear concurrent with a PERFECT strobe, and rst asserted mid-conversion → combo=0, FSM=IDLE, all blank, o_bcd_busy=0.
